// File: rtl/if_id_buffer.sv
// ============================================================================
// if_id_buffer : two-entry fetch/decode skid FIFO tagging illegal fetch PCs
// Revision     : 1.0
// ============================================================================
`default_nettype none

module if_id_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic [31:0] pc8_out,
    output logic        adel_out,
    output logic [1:0]  count
);

    localparam logic [31:0] c_im_lo = 32'h0000_3000;
    localparam logic [31:0] c_im_hi = 32'h0000_6FFC;

    logic [31:0] pc_q    [2];
    logic [31:0] instr_q [2];
    logic        adel_q  [2];

    logic        wptr_q,  wptr_d;
    logic        rptr_q,  rptr_d;
    logic [1:0]  count_q, count_d;

    logic        push;
    logic        pop;
    logic        adel_in;
    logic [31:0] head_pc;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign count     = count_q;

    assign push    = in_valid && in_ready && !flush;
    assign pop     = out_valid && out_ready && !flush;
    assign adel_in = (pc_in[1:0] != 2'b00) || (pc_in < c_im_lo) || (pc_in > c_im_hi);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
            pc_q[0]    <= 32'd0;
            pc_q[1]    <= 32'd0;
            instr_q[0] <= 32'd0;
            instr_q[1] <= 32'd0;
            adel_q[0]  <= 1'b0;
            adel_q[1]  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) begin
                // An illegal fetch is stored as a nop but keeps its PC for the exception path
                pc_q[wptr_q]    <= pc_in;
                instr_q[wptr_q] <= adel_in ? 32'd0 : instr_in;
                adel_q[wptr_q]  <= adel_in;
            end
        end
    end

    assign head_pc   = pc_q[rptr_q];
    assign instr_out = out_valid ? instr_q[rptr_q]   : 32'd0;
    assign pc4_out   = out_valid ? head_pc + 32'd4   : 32'd0;
    assign pc8_out   = out_valid ? head_pc + 32'd8   : 32'd0;
    assign adel_out  = out_valid ? adel_q[rptr_q]    : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ============================================================================
// tb_if_id_buffer : directed self-checking bench for if_id_buffer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic [31:0] pc8_out;
    logic        adel_out;
    logic [1:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    if_id_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .instr_out (instr_out),
        .pc4_out   (pc4_out),
        .pc8_out   (pc8_out),
        .adel_out  (adel_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        pc_in    = pc;
        instr_in = ins;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("rst_count",     {30'd0, count}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr",     instr_out, 32'd0);
        chk("rst_pc4",       pc4_out, 32'd0);
        chk("rst_pc8",       pc8_out, 32'd0);
        chk("rst_adel",      {31'd0, adel_out}, 32'd0);
        step(); step();
        reset = 1'b0;

        // basic flow
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_3000, 32'h2408_0001);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_pc4",   pc4_out, 32'h0000_3004);
        chk("basic_pc8",   pc8_out, 32'h0000_3008);
        chk("basic_instr", instr_out, 32'h2408_0001);
        chk("basic_count", {30'd0, count}, 32'd1);
        step();
        chk("basic_drain_count", {30'd0, count}, 32'd0);
        chk("basic_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_drain_instr", instr_out, 32'd0);

        // fill and stall
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'hA000_0001); step();
        drive(1'b1, 32'h0000_3004, 32'hA000_0002); step();
        chk("full_count",    {30'd0, count}, 32'd2);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h0000_3008, 32'hA000_0003); step();
        drive(1'b0, 32'd0, 32'd0);
        chk("full_ignore_count", {30'd0, count}, 32'd2);
        chk("full_head0_pc4",    pc4_out, 32'h0000_3004);
        chk("full_head0_instr",  instr_out, 32'hA000_0001);
        out_ready = 1'b1;
        step();
        chk("full_head1_pc4",   pc4_out, 32'h0000_3008);
        chk("full_head1_instr", instr_out, 32'hA000_0002);
        chk("full_head1_count", {30'd0, count}, 32'd1);
        step();
        chk("full_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("full_empty_count", {30'd0, count}, 32'd0);
        step();
        chk("empty_pop_count", {30'd0, count}, 32'd0);

        // simultaneous push/pop and streaming with pointer wrap
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'hB000_3000); step();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_3004, 32'hB000_3004); step();
        chk("pp_count", {30'd0, count}, 32'd1);
        chk("pp_head",  pc4_out, 32'h0000_3008);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0000_3008 + 32'(4 * i), 32'hB000_3008 + 32'(4 * i));
            step();
            chk("stream_count", {30'd0, count}, 32'd1);
            chk("stream_pc4",   pc4_out, 32'h0000_300C + 32'(4 * i));
            chk("stream_instr", instr_out, 32'hB000_3008 + 32'(4 * i));
        end
        drive(1'b0, 32'd0, 32'd0); step();
        chk("stream_end_count", {30'd0, count}, 32'd0);

        // flush beats a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'hC000_0001); step();
        drive(1'b1, 32'h0000_3004, 32'hC000_0002); step();
        flush = 1'b1;
        drive(1'b1, 32'h0000_3010, 32'hC000_0010); step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_instr", instr_out, 32'd0);
        step();
        chk("flush_absent", {30'd0, count}, 32'd0);
        drive(1'b1, 32'h0000_3020, 32'hC000_0020); step();
        drive(1'b0, 32'd0, 32'd0);
        chk("post_flush_pc4",   pc4_out, 32'h0000_3024);
        chk("post_flush_instr", instr_out, 32'hC000_0020);
        out_ready = 1'b1; step();
        out_ready = 1'b0;

        // illegal fetch addresses and range edges
        drive(1'b1, 32'h0000_3002, 32'hFFFF_FFFF); step();
        drive(1'b1, 32'h0000_7000, 32'h1234_5678); step();
        drive(1'b0, 32'd0, 32'd0);
        chk("adel_mis_flag",  {31'd0, adel_out}, 32'd1);
        chk("adel_mis_instr", instr_out, 32'd0);
        chk("adel_mis_pc4",   pc4_out, 32'h0000_3006);
        out_ready = 1'b1; step();
        chk("adel_hi_flag",  {31'd0, adel_out}, 32'd1);
        chk("adel_hi_instr", instr_out, 32'd0);
        chk("adel_hi_pc4",   pc4_out, 32'h0000_7004);
        drive(1'b1, 32'h0000_6FFC, 32'h0000_6FFC); step();
        chk("edge_hi_flag",  {31'd0, adel_out}, 32'd0);
        chk("edge_hi_instr", instr_out, 32'h0000_6FFC);
        chk("edge_hi_pc8",   pc8_out, 32'h0000_7004);
        drive(1'b1, 32'h0000_2FFC, 32'h0000_2FFC); step();
        chk("edge_lo_flag", {31'd0, adel_out}, 32'd1);
        drive(1'b1, 32'hFFFF_FFFC, 32'h1111_1111); step();
        chk("wrap_flag", {31'd0, adel_out}, 32'd1);
        chk("wrap_pc4",  pc4_out, 32'h0000_0000);
        chk("wrap_pc8",  pc8_out, 32'h0000_0004);
        drive(1'b0, 32'd0, 32'd0); step();
        chk("adel_end_count", {30'd0, count}, 32'd0);

        // asynchronous reset between edges
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'hD000_0001); step();
        drive(1'b1, 32'h0000_3004, 32'hD000_0002); step();
        drive(1'b0, 32'd0, 32'd0);
        chk("ar_pre_count", {30'd0, count}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid",    {31'd0, out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_count",    {30'd0, count}, 32'd0);
        chk("ar_pc4",      pc4_out, 32'd0);
        reset = 1'b0;
        drive(1'b1, 32'h0000_3040, 32'hD000_0040);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("ar_push_count", {30'd0, count}, 32'd1);
        chk("ar_push_pc4",   pc4_out, 32'h0000_3044);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port pc_in, input, 32 bits: fetch address of the instruction presented (NPC output).
REQ-004 The block SHALL have port instr_in, input, 32 bits: instruction word read from IM at pc_in.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the fetch stage offers pc_in/instr_in this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the buffer accepts an entry this cycle.
REQ-007 The block SHALL have port out_ready, input, 1 bit: decode consumes the head entry (deasserted while decode stalls).
REQ-008 The block SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a head entry is present.
REQ-010 The block SHALL have port instr_out, output, 32 bits: head instruction, or 0 (nop) on bubble.
REQ-011 The block SHALL have port pc4_out, output, 32 bits: head pc + 4, feeding NPC pc4.
REQ-012 The block SHALL have port pc8_out, output, 32 bits: head pc + 8 (link value).
REQ-013 The block SHALL have port adel_out, output, 1 bit: the head fetch address is illegal.
REQ-014 The block SHALL have port count, output, 2 bits: number of occupied entries (0..2).

Function
REQ-015 The block SHALL be a 2-entry FIFO of {pc[31:0], instr[31:0], adel}, using 1-bit write and read pointers and a 2-bit occupancy counter.
REQ-016 in_ready SHALL be 1 iff count < 2; it is combinational from count only and has no dependency on out_ready.
REQ-017 A push SHALL occur on an edge where in_valid && in_ready && !flush; the entry is written at the write pointer, and the write pointer toggles.
REQ-018 A pop SHALL occur on an edge where out_valid && out_ready && !flush; the read pointer toggles.
REQ-019 Occupancy SHALL update as: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-020 On a push, adel SHALL be set iff pc_in[1:0] != 0 or pc_in is outside the range 0x0000_3000..0x0000_6FFC inclusive.
REQ-021 When adel is set, the stored instr SHALL be 0 and the stored pc SHALL equal pc_in unmodified.
REQ-022 out_valid SHALL be 1 iff count != 0.
REQ-023 The outputs SHALL be combinational from the head entry (read pointer); the first pushed entry is visible one cycle after its push edge.
REQ-024 When count == 0, the outputs SHALL be instr_out = 0, pc4_out = 0, pc8_out = 0, adel_out = 0.
REQ-025 pc4_out and pc8_out SHALL be computed as 32-bit modulo sums; a carry out of bit 31 is dropped.
REQ-026 flush SHALL act synchronously and have priority over push and pop: at the edge, count = 0 and both pointers = 0, and any same-cycle push is discarded.
REQ-027 When full (count == 2), in_valid SHALL be ignored; a same-cycle pop frees a slot that is usable only from the next cycle.
REQ-028 When empty, out_ready SHALL be ignored, and count SHALL never underflow or exceed 2.
REQ-029 The FIFO order SHALL be strict: entries leave in push order, and pointer wrap from 1 to 0 is seamless.

Reset
REQ-030 While reset = 1, asynchronously: count = 0, both pointers = 0, all entry storage = 0, and therefore out_valid = 0, in_ready = 1, and instr_out/pc4_out/pc8_out/adel_out = 0.
REQ-031 Reset asserted mid-operation SHALL drop all entries immediately, without waiting for a clock edge; the first push after reset is deasserted is taken on the next rising edge.
REQ-032 Reset SHALL have priority over flush, push and pop.

Verification
REQ-033 Basic flow: reset, then push pc 0x3000 / instr 0x2408_0001 with out_ready = 1 -> next cycle out_valid = 1, pc4_out = 0x3004, pc8_out = 0x3008, instr_out = 0x2408_0001, and count returns to 0 after the pop.
REQ-034 Fill and stall: out_ready = 0, push 0x3000 then 0x3004 -> count = 2, in_ready = 0; a third push of 0x3008 is ignored; then with out_ready = 1 the heads are 0x3004 then 0x3008 (pc4_out values), then out_valid = 0.
REQ-035 Simultaneous push and pop at count = 1 -> count stays 1, and the next head is the newer entry; run continuous streaming over 8 addresses to exercise pointer wrap, with no loss or reordering.
REQ-036 Flush with count = 2 and a concurrent push of 0x3010 -> next cycle count = 0, out_valid = 0, instr_out = 0, and 0x3010 is absent.
REQ-037 Illegal fetch: push pc 0x3002, then push pc 0x7000 -> each head shows adel_out = 1, instr_out = 0, and pc4_out of 0x3006 and 0x7004 respectively.
REQ-038 Asynchronous reset pulsed between edges while count = 2 -> out_valid drops to 0 and in_ready rises to 1 before the next edge.
